// File: rtl/seg_display_driver.sv
// seg_display_driver
// Converts the 8-bit count qd into three BCD digits with a sequential
// double-dabble engine. Drives a 4-digit common-anode multiplexed
// seven-segment display with optional leading-zero blanking.
//
// Ports:
//   clk      in   rising-edge clock
//   clear    in   asynchronous active-high reset
//   qd       in   [7:0] unsigned value to display
//   an       out  [3:0] digit anodes, active-low (slot 3 = all dark)
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp       out  decimal point, active-low, held off
//   bcd_out  out  [11:0] {hundreds, tens, ones} currently displayed
//   busy     out  high while a conversion is in flight
module seg_display_driver #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [7:0]  qd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [11:0] bcd_out,
  output logic        busy
);

  localparam int unsigned BIN_W = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  // Active-low glyphs; non-decimal nibbles render as blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t              r_state;
  logic [SR_W-1:0]     r_sr;
  logic [2:0]          r_iter;
  logic [BIN_W-1:0]    r_cap;
  logic [BIN_W-1:0]    r_shown;
  logic [BCD_W-1:0]    r_bcd;
  logic                r_busy;
  logic [CNT_W-1:0]    r_refresh;
  logic [1:0]          r_slot;
  logic [3:0]          r_an;
  logic [6:0]          r_seg;

  logic [SR_W-1:0]     w_adj;
  logic                w_blank_hund;
  logic                w_blank_tens;
  logic [3:0]          w_an_nxt;
  logic [6:0]          w_seg_nxt;

  // Add-3 correction on every BCD nibble >= 5 before the shift.
  always_comb begin
    w_adj = r_sr;
    for (int i = 0; i < 3; i++) begin
      if (r_sr[BIN_W + 4*i +: 4] >= 4'd5)
        w_adj[BIN_W + 4*i +: 4] = r_sr[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM: IDLE compares, SHIFT runs 8 iterations, LOAD publishes.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_iter  <= '0;
      r_cap   <= '0;
      r_shown <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (qd != r_shown) begin
            r_sr    <= {BCD_W'(0), qd};
            r_cap   <= qd;
            r_iter  <= '0;
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_sr   <= {w_adj[SR_W-2:0], 1'b0};
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_bcd   <= r_sr[SR_W-1:BIN_W];
          r_shown <= r_cap;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Hundreds blank at zero; tens blank only when hundreds is also zero.
  assign w_blank_hund = BLANK_LEADING && (r_bcd[11:8] == 4'd0);
  assign w_blank_tens = w_blank_hund && (r_bcd[7:4] == 4'd0);

  // Next anode/segment pattern from the current slot and published digits.
  always_comb begin
    w_an_nxt  = 4'b1111;
    w_seg_nxt = SEG_BLANK;
    case (r_slot)
      2'd0: begin
        w_an_nxt  = 4'b1110;
        w_seg_nxt = seg_decode(r_bcd[3:0]);
      end
      2'd1: begin
        w_an_nxt  = 4'b1101;
        w_seg_nxt = w_blank_tens ? SEG_BLANK : seg_decode(r_bcd[7:4]);
      end
      2'd2: begin
        w_an_nxt  = 4'b1011;
        w_seg_nxt = w_blank_hund ? SEG_BLANK : seg_decode(r_bcd[11:8]);
      end
      default: begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
      end
    endcase
  end

  // Refresh timer, slot rotation and registered display outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_refresh <= '0;
      r_slot    <= '0;
      r_an      <= 4'b1111;
      r_seg     <= SEG_BLANK;
    end else begin
      if (r_refresh == CNT_TERM) begin
        r_refresh <= '0;
        r_slot    <= r_slot + 2'd1;
      end else begin
        r_refresh <= r_refresh + CNT_W'(1);
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an      = r_an;
  assign seg     = r_seg;
  assign dp      = 1'b1;
  assign bcd_out = r_bcd;
  assign busy    = r_busy;

endmodule

// File: tb/tb_seg_display_driver.sv
// Testbench for seg_display_driver: two instances (blanking on/off) share
// stimulus; results are compared with a decimal-arithmetic reference model.
module tb_seg_display_driver;

  localparam int unsigned RD = 4;

  logic        clk = 1'b0;
  logic        clear;
  logic [7:0]  qd;
  logic [3:0]  an,      an_nb;
  logic [6:0]  seg,     seg_nb;
  logic        dp,      dp_nb;
  logic [11:0] bcd_out, bcd_nb;
  logic        busy,    busy_nb;

  int checks = 0;
  int errors = 0;
  int shown_m = 0;

  seg_display_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .clear(clear), .qd(qd), .an(an), .seg(seg), .dp(dp),
    .bcd_out(bcd_out), .busy(busy)
  );

  seg_display_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .clear(clear), .qd(qd), .an(an_nb), .seg(seg_nb), .dp(dp_nb),
    .bcd_out(bcd_nb), .busy(busy_nb)
  );

  always #5 clk = ~clk;

  // Reference model ---------------------------------------------------------
  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input int v, input int pos, input bit blank);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (pos == 2) return (blank && h == 0) ? 7'b1111111 : ref_glyph(h);
    if (pos == 1) return (blank && h == 0 && t == 0) ? 7'b1111111 : ref_glyph(t);
    return ref_glyph(o);
  endfunction

  // Apply a new qd, expect a 9-cycle busy pulse and the right BCD result.
  task automatic convert(input int v);
    int cnt;
    @(negedge clk);
    qd = 8'(v);
    @(negedge clk);
    if (v == shown_m) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL convert_same qd=%0d busy=%b required 0", v, busy);
      end
    end else begin
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
        cnt++;
        @(negedge clk);
      end
      checks++;
      if (cnt != 9) begin
        errors++;
        $display("FAIL busy_len qd=%0d cycles=%0d required 9", v, cnt);
      end
    end
    checks++;
    if (bcd_out !== ref_bcd(v)) begin
      errors++;
      $display("FAIL bcd qd=%0d bcd_out=%h required %h", v, bcd_out, ref_bcd(v));
    end
    checks++;
    if (bcd_nb !== ref_bcd(v)) begin
      errors++;
      $display("FAIL bcd_nb qd=%0d bcd_out=%h required %h", v, bcd_nb, ref_bcd(v));
    end
    shown_m = v;
  endtask

  // Observe one full frame on both instances: glyphs and per-anode dwell.
  task automatic check_frame(input int v);
    int low [2][4];
    logic [3:0] a;
    logic [6:0] s;
    bit blk;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) low[d][k] = 0;
    for (int c = 0; c < 4 * int'(RD); c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        a   = (d == 0) ? an  : an_nb;
        s   = (d == 0) ? seg : seg_nb;
        blk = (d == 0);
        case (a)
          4'b1110, 4'b1101, 4'b1011: begin
            int pos;
            pos = (a == 4'b1110) ? 0 : (a == 4'b1101) ? 1 : 2;
            low[d][pos]++;
            checks++;
            if (s !== ref_seg(v, pos, blk)) begin
              errors++;
              $display("FAIL seg inst=%0d qd=%0d pos=%0d seg=%b required %b",
                       d, v, pos, s, ref_seg(v, pos, blk));
            end
          end
          4'b1111: low[d][3]++;
          default: begin
            checks++;
            errors++;
            $display("FAIL an_pattern inst=%0d an=%b required one-hot-low or 1111", d, a);
          end
        endcase
      end
    end
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (low[d][k] != int'(RD)) begin
          errors++;
          $display("FAIL dwell inst=%0d slot=%0d cycles=%0d required %0d",
                   d, k, low[d][k], RD);
        end
      end
  endtask

  // Tests ------------------------------------------------------------------
  task automatic test_reset();
    clear = 1'b1;
    qd    = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp, bcd_out, busy} !== {4'b1111, 7'b1111111, 1'b1, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state an=%b seg=%b dp=%b bcd=%h busy=%b required 1111 1111111 1 000 0",
               an, seg, dp, bcd_out, busy);
    end
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL first_digit an=%b seg=%b required 1110 1000000", an, seg);
    end
    shown_m = 0;
    check_frame(0);
  endtask

  task automatic test_ten();
    convert(10);
    check_frame(10);
  endtask

  task automatic test_255();
    convert(255);
    check_frame(255);
  endtask

  task automatic test_down_wrap();
    convert(10);
    check_frame(10);
    convert(0);
    check_frame(0);
  endtask

  task automatic test_back_to_back();
    int cnt;
    int hi;
    bit saw7;
    saw7 = 1'b0;
    @(negedge clk);
    qd = 8'd3;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start busy=%b required 1", busy);
    end
    qd = 8'd7;
    @(negedge clk);
    qd = 8'd9;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (bcd_out === 12'h007) saw7 = 1'b1;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (bcd_out !== 12'h003) begin
      errors++;
      $display("FAIL b2b_first bcd_out=%h required 003", bcd_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart busy=%b required 1", busy);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (bcd_out === 12'h007) saw7 = 1'b1;
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (bcd_out !== 12'h009) begin
      errors++;
      $display("FAIL b2b_second bcd_out=%h required 009", bcd_out);
    end
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy === 1'b1) hi++;
      if (bcd_out === 12'h007) saw7 = 1'b1;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL b2b_extra busy_cycles=%0d required 0", hi);
    end
    checks++;
    if (saw7) begin
      errors++;
      $display("FAIL b2b_skip shown_007=%b required 0", saw7);
    end
    shown_m = 9;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    qd = 8'd200;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy busy=%b required 1", busy);
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if ({an, seg, bcd_out, busy, bcd_nb, busy_nb} !==
        {4'b1111, 7'b1111111, 12'h000, 1'b0, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset an=%b seg=%b bcd=%h busy=%b bcd_nb=%h busy_nb=%b required 1111 1111111 000 0 000 0",
               an, seg, bcd_out, busy, bcd_nb, busy_nb);
    end
    qd = 8'd0;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || busy !== 1'b0 || bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL mid_release an=%b seg=%b busy=%b bcd=%h required 1110 1000000 0 000",
               an, seg, busy, bcd_out);
    end
    shown_m = 0;
    check_frame(0);
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      convert(v);
      check_frame(v);
    end
  endtask

  task automatic test_random();
    int v;
    repeat (12) begin
      v = int'($urandom_range(0, 255));
      convert(v);
      check_frame(v);
    end
  endtask

  initial begin
    test_reset();
    test_ten();
    test_255();
    test_down_wrap();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
